crc_chk_sched: RTL and testbench

//  Scheduler that shares one bit-serial CRC check engine among N_REQ receive lanes.
//  - Round-robin arbitration over lanes; grants one codeword at a time.
//  - Launches the engine, waits for completion, returns pass/fail and remainder to the granted lane.
//  - A watchdog catches an engine that never completes.

---
 rtl/crc_chk_sched_pkg.sv | 29 ++
 rtl/crc_chk_sched_rr_arbiter.sv | 46 ++++
 rtl/crc_chk_sched.sv | 235 +++++++++++++++++++++++
 tb/tb_crc_chk_sched.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/crc_chk_sched_pkg.sv
// Shared definitions for the CRC check scheduler: default geometry, the CRC
// polynomial used by the attached engine, FSM encoding and small helpers.
package crc_chk_sched_pkg;

    localparam int         DEF_N_REQ       = 4;
    localparam int         DEF_CRC_LENGTH  = 8;
    localparam int         DEF_DATA_LENGTH = 32;
    localparam logic [7:0] DEF_CRC_POLY    = 8'h07;

    // Scheduler states; encoding is fixed so debug tools can decode it.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_BUSY   = 2'd2,
        ST_RESP   = 2'd3
    } sched_state_e;

    // Lane index following idx, wrapping from n-1 back to 0.
    function automatic int next_lane(input int idx, input int n);
        int nxt;
        if (idx >= n - 1) begin
            nxt = 0;
        end else begin
            nxt = idx + 1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/crc_chk_sched_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requesting lane at or
// after the pointer, wrapping around, and returns it one-hot and as an index.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic             gnt_any,
    output logic [N_REQ-1:0] gnt_onehot,
    output logic [IDX_W-1:0] gnt_idx
);

    int               cand_s;
    logic [IDX_W-1:0] cand_idx_s;

    // Scan lanes starting at the pointer; the first requester found wins.
    always_comb begin
        gnt_any    = 1'b0;
        gnt_idx    = '0;
        gnt_onehot = '0;
        cand_s     = 0;
        cand_idx_s = '0;
        for (int off = 0; off < N_REQ; off++) begin
            cand_s = int'(ptr) + off;
            if (cand_s >= N_REQ) begin
                cand_s = cand_s - N_REQ;
            end else begin
                cand_s = cand_s;
            end
            cand_idx_s = IDX_W'(cand_s);
            if (!gnt_any && req[cand_idx_s]) begin
                gnt_any = 1'b1;
                gnt_idx = cand_idx_s;
            end else begin
                gnt_any = gnt_any;
            end
        end
        if (gnt_any) begin
            gnt_onehot[gnt_idx] = 1'b1;
        end else begin
            gnt_onehot = '0;
        end
    end

endmodule

// File: rtl/crc_chk_sched.sv
// Shares one bit-serial CRC check engine among N_REQ receive lanes.
// Lanes are served round-robin, one codeword at a time; a watchdog turns an
// engine that never answers into a timeout response.
module crc_chk_sched
    import crc_chk_sched_pkg::*;
#(
    parameter int  N_REQ       = DEF_N_REQ,
    parameter int  CRC_LENGTH  = DEF_CRC_LENGTH,
    parameter int  DATA_LENGTH = DEF_DATA_LENGTH,
    parameter int  TIMEOUT     = DATA_LENGTH + 8,
    localparam int CW_W        = CRC_LENGTH + DATA_LENGTH,
    localparam int IDX_W       = $clog2(N_REQ),
    localparam int WD_W        = $clog2(TIMEOUT + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*CW_W-1:0]   req_data,
    output logic [N_REQ-1:0]        req_ready,
    output logic                    eng_start,
    output logic [CW_W-1:0]         eng_din,
    input  logic                    eng_vld,
    input  logic [CRC_LENGTH-1:0]   eng_rem,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [IDX_W-1:0]        rsp_id,
    output logic                    rsp_ok,
    output logic [CRC_LENGTH-1:0]   rsp_rem,
    output logic                    rsp_timeout
);

    localparam logic [WD_W-1:0] WD_MAX  = '1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    sched_state_e            state_r;
    sched_state_e            state_nx;
    logic [IDX_W-1:0]        rr_ptr_r;
    logic                    armed_r;
    logic [WD_W-1:0]         wd_r;

    logic                    gnt_any_s;
    logic [N_REQ-1:0]        gnt_onehot_s;
    logic [IDX_W-1:0]        gnt_idx_s;

    logic                    accept_s;
    logic                    wd_clr_s;
    logic                    wd_inc_s;
    logic                    done_vld_s;
    logic                    done_to_s;
    logic                    rsp_hs_s;

    logic                    eng_start_r;
    logic [CW_W-1:0]         eng_din_r;
    logic                    rsp_valid_r;
    logic [IDX_W-1:0]        rsp_id_r;
    logic                    rsp_ok_r;
    logic [CRC_LENGTH-1:0]   rsp_rem_r;
    logic                    rsp_timeout_r;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .req        (req_valid),
        .ptr        (rr_ptr_r),
        .gnt_any    (gnt_any_s),
        .gnt_onehot (gnt_onehot_s),
        .gnt_idx    (gnt_idx_s)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx;
        end
    end

    // Next-state decode and one-cycle control strobes.
    always_comb begin
        state_nx   = state_r;
        accept_s   = 1'b0;
        wd_clr_s   = 1'b0;
        wd_inc_s   = 1'b0;
        done_vld_s = 1'b0;
        done_to_s  = 1'b0;
        rsp_hs_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                // armed_r keeps req_ready low while reset is asserted.
                if (armed_r && gnt_any_s) begin
                    accept_s = 1'b1;
                    state_nx = ST_LAUNCH;
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            ST_LAUNCH: begin
                wd_clr_s = 1'b1;
                state_nx = ST_BUSY;
            end
            ST_BUSY: begin
                wd_inc_s = 1'b1;
                // A completion in the watchdog's last cycle still counts as done.
                if (eng_vld) begin
                    done_vld_s = 1'b1;
                    state_nx   = ST_RESP;
                end else if (wd_r == WD_LAST) begin
                    done_to_s = 1'b1;
                    state_nx  = ST_RESP;
                end else begin
                    state_nx = ST_BUSY;
                end
            end
            ST_RESP: begin
                if (rsp_valid_r && rsp_ready) begin
                    rsp_hs_s = 1'b1;
                    state_nx = ST_IDLE;
                end else begin
                    state_nx = ST_RESP;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // Accept pulse goes to the granted lane in the same cycle as the grant.
    always_comb begin
        if (accept_s) begin
            req_ready = gnt_onehot_s;
        end else begin
            req_ready = '0;
        end
    end

    // Enable flag that opens the acceptance path one cycle after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed_r <= 1'b0;
        end else begin
            armed_r <= 1'b1;
        end
    end

    // Round-robin pointer moves past the served lane once its response is taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_r <= '0;
        end else if (rsp_hs_s) begin
            rr_ptr_r <= IDX_W'(next_lane(int'(rsp_id_r), N_REQ));
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end

    // Codeword latch and engine start pulse; eng_din holds until the next grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eng_din_r   <= '0;
            eng_start_r <= 1'b0;
        end else if (accept_s) begin
            eng_din_r   <= req_data[gnt_idx_s*CW_W +: CW_W];
            eng_start_r <= 1'b1;
        end else begin
            eng_din_r   <= eng_din_r;
            eng_start_r <= 1'b0;
        end
    end

    // Watchdog: cleared at launch, counts BUSY cycles, saturates instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_r <= '0;
        end else if (wd_clr_s) begin
            wd_r <= '0;
        end else if (wd_inc_s && (wd_r != WD_MAX)) begin
            wd_r <= wd_r + {{(WD_W-1){1'b0}}, 1'b1};
        end else begin
            wd_r <= wd_r;
        end
    end

    // Response registers: loaded on engine completion or timeout, held until taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_r   <= 1'b0;
            rsp_id_r      <= '0;
            rsp_ok_r      <= 1'b0;
            rsp_rem_r     <= '0;
            rsp_timeout_r <= 1'b0;
        end else if (accept_s) begin
            rsp_valid_r   <= 1'b0;
            rsp_id_r      <= gnt_idx_s;
            rsp_ok_r      <= rsp_ok_r;
            rsp_rem_r     <= rsp_rem_r;
            rsp_timeout_r <= rsp_timeout_r;
        end else if (done_vld_s) begin
            rsp_valid_r   <= 1'b1;
            rsp_id_r      <= rsp_id_r;
            rsp_ok_r      <= (eng_rem == {CRC_LENGTH{1'b0}});
            rsp_rem_r     <= eng_rem;
            rsp_timeout_r <= 1'b0;
        end else if (done_to_s) begin
            rsp_valid_r   <= 1'b1;
            rsp_id_r      <= rsp_id_r;
            rsp_ok_r      <= 1'b0;
            rsp_rem_r     <= '0;
            rsp_timeout_r <= 1'b1;
        end else if (rsp_hs_s) begin
            rsp_valid_r   <= 1'b0;
            rsp_id_r      <= rsp_id_r;
            rsp_ok_r      <= rsp_ok_r;
            rsp_rem_r     <= rsp_rem_r;
            rsp_timeout_r <= rsp_timeout_r;
        end else begin
            rsp_valid_r   <= rsp_valid_r;
            rsp_id_r      <= rsp_id_r;
            rsp_ok_r      <= rsp_ok_r;
            rsp_rem_r     <= rsp_rem_r;
            rsp_timeout_r <= rsp_timeout_r;
        end
    end

    assign eng_start   = eng_start_r;
    assign eng_din     = eng_din_r;
    assign rsp_valid   = rsp_valid_r;
    assign rsp_id      = rsp_id_r;
    assign rsp_ok      = rsp_ok_r;
    assign rsp_rem     = rsp_rem_r;
    assign rsp_timeout = rsp_timeout_r;

endmodule

// File: tb/tb_crc_chk_sched.sv
// Directed bench for crc_chk_sched with a behavioural bit-serial CRC engine
// attached; expected responses are hand-computed constants.
module tb_crc_chk_sched;
    import crc_chk_sched_pkg::*;

    localparam int N_REQ   = 4;
    localparam int CRC_L   = 8;
    localparam int DATA_L  = 32;
    localparam int CW_W    = CRC_L + DATA_L;
    localparam int TIMEOUT = DATA_L + 8;

    logic                  clk;
    logic                  rst_n;
    logic [N_REQ-1:0]      req_valid;
    logic [N_REQ*CW_W-1:0] req_data;
    logic [N_REQ-1:0]      req_ready;
    logic                  eng_start;
    logic [CW_W-1:0]       eng_din;
    logic                  eng_vld;
    logic [CRC_L-1:0]      eng_rem;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [1:0]            rsp_id;
    logic                  rsp_ok;
    logic [CRC_L-1:0]      rsp_rem;
    logic                  rsp_timeout;

    logic [CW_W-1:0]       lane_cw [N_REQ];
    logic                  eng_dead;
    logic                  eng_vld_inj;
    logic                  eng_vld_m;
    logic [CRC_L-1:0]      eng_rem_m;
    int                    eng_cnt;
    int                    n_total;
    int                    n_bad;

    crc_chk_sched #(
        .N_REQ       (N_REQ),
        .CRC_LENGTH  (CRC_L),
        .DATA_LENGTH (DATA_L),
        .TIMEOUT     (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .eng_start   (eng_start),
        .eng_din     (eng_din),
        .eng_vld     (eng_vld),
        .eng_rem     (eng_rem),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_ok      (rsp_ok),
        .rsp_rem     (rsp_rem),
        .rsp_timeout (rsp_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign req_data = {lane_cw[3], lane_cw[2], lane_cw[1], lane_cw[0]};
    assign eng_vld  = eng_vld_m | eng_vld_inj;
    assign eng_rem  = eng_rem_m;

    // Remainder of the codeword divided by the CRC polynomial, MSB first.
    function automatic logic [CRC_L-1:0] crc_rem(input logic [CW_W-1:0] cw);
        logic [CRC_L-1:0] r;
        logic             fb;
        r = 8'h00;
        for (int i = CW_W - 1; i >= 0; i--) begin
            fb = r[7];
            r  = {r[6:0], cw[i]};
            if (fb) r = r ^ DEF_CRC_POLY;
        end
        return r;
    endfunction

    // Engine model: eng_vld pulses DATA_L+1 cycles after the start edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eng_cnt   <= 0;
            eng_vld_m <= 1'b0;
            eng_rem_m <= 8'h00;
        end else begin
            eng_vld_m <= 1'b0;
            if (eng_start && !eng_dead) begin
                eng_cnt   <= DATA_L;
                eng_rem_m <= crc_rem(eng_din);
            end else if (eng_cnt != 0) begin
                eng_cnt <= eng_cnt - 1;
                if (eng_cnt == 1) eng_vld_m <= 1'b1;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_total++;
        if (obs !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Waits for the accept pulse, then checks the launch cycle and the start pulse width.
    task automatic wait_grant(input string tag, input int lane);
        int         n;
        logic [3:0] oh;
        n  = 0;
        oh = 4'b0001 << lane;
        #1;
        while (req_ready == 4'b0000 && n < 200) begin
            step();
            n++;
        end
        check_eq({tag, "_grant"}, 64'(req_ready), 64'(oh));
        step();
        check_eq({tag, "_start"}, 64'(eng_start), 64'd1);
        check_eq({tag, "_din"}, 64'(eng_din), 64'(lane_cw[lane]));
        check_eq({tag, "_rdy_launch"}, 64'(req_ready), 64'd0);
        step();
        check_eq({tag, "_start_end"}, 64'(eng_start), 64'd0);
    endtask

    // Waits for the response, checks it, optionally stalls, then takes it.
    task automatic wait_rsp(input string tag, input int id, input logic ok,
                            input logic [7:0] rem, input logic to, input int lat,
                            input int hold);
        int n;
        int bad;
        n = 0;
        while (!rsp_valid && n < 200) begin
            step();
            n++;
        end
        check_eq({tag, "_valid"}, 64'(rsp_valid), 64'd1);
        check_eq({tag, "_lat"}, 64'(n), 64'(lat));
        check_eq({tag, "_id"}, 64'(rsp_id), 64'(id));
        check_eq({tag, "_ok"}, 64'(rsp_ok), 64'(ok));
        check_eq({tag, "_rem"}, 64'(rsp_rem), 64'(rem));
        check_eq({tag, "_to"}, 64'(rsp_timeout), 64'(to));
        bad = 0;
        for (int i = 0; i < hold; i++) begin
            step();
            if (rsp_valid !== 1'b1 || rsp_id !== 2'(id) || rsp_ok !== ok ||
                rsp_rem !== rem || rsp_timeout !== to || req_ready !== 4'b0000) bad++;
        end
        if (hold > 0) check_eq({tag, "_hold"}, 64'(bad), 64'd0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check_eq({tag, "_drop"}, 64'(rsp_valid), 64'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        n_total     = 0;
        n_bad       = 0;
        rst_n       = 1'b0;
        req_valid   = 4'b0000;
        rsp_ready   = 1'b0;
        eng_dead    = 1'b0;
        eng_vld_inj = 1'b0;
        lane_cw[0]  = 40'h00_0000_0000;
        lane_cw[1]  = 40'h00_0000_0107;
        lane_cw[2]  = 40'h00_0000_0001;
        lane_cw[3]  = 40'h00_0000_005A;
        repeat (3) step();

        // Reset state
        check_eq("rst_ready", 64'(req_ready), 64'd0);
        check_eq("rst_start", 64'(eng_start), 64'd0);
        check_eq("rst_din", 64'(eng_din), 64'd0);
        check_eq("rst_valid", 64'(rsp_valid), 64'd0);
        check_eq("rst_id", 64'(rsp_id), 64'd0);
        check_eq("rst_ok", 64'(rsp_ok), 64'd0);
        check_eq("rst_rem", 64'(rsp_rem), 64'd0);
        check_eq("rst_to", 64'(rsp_timeout), 64'd0);
        rst_n = 1'b1;
        step();

        // Lane 0, all-zero codeword: clean pass
        req_valid = 4'b0001;
        wait_grant("t1", 0);
        req_valid = 4'b0000;
        wait_rsp("t1", 0, 1'b1, 8'h00, 1'b0, DATA_L + 1, 0);

        // Lane 2, codeword 1: remainder 01
        req_valid = 4'b0100;
        wait_grant("t2", 2);
        req_valid = 4'b0000;
        wait_rsp("t2", 2, 1'b0, 8'h01, 1'b0, DATA_L + 1, 0);

        // Lane 1, data 1 with its correct CRC 07: pass
        req_valid = 4'b0010;
        wait_grant("t2b", 1);
        req_valid = 4'b0000;
        wait_rsp("t2b", 1, 1'b1, 8'h00, 1'b0, DATA_L + 1, 0);

        // Stray eng_vld and rsp_ready while idle are ignored
        eng_vld_inj = 1'b1;
        rsp_ready   = 1'b1;
        step();
        eng_vld_inj = 1'b0;
        rsp_ready   = 1'b0;
        step();
        check_eq("idle_vld_rsp", 64'(rsp_valid), 64'd0);
        check_eq("idle_vld_start", 64'(eng_start), 64'd0);

        // Reset during BUSY, then lane 0 regranted from pointer 0
        req_valid = 4'b1000;
        wait_grant("t6", 3);
        repeat (5) step();
        rst_n     = 1'b0;
        req_valid = 4'b1001;
        #1;
        check_eq("t6_rst_ready", 64'(req_ready), 64'd0);
        check_eq("t6_rst_start", 64'(eng_start), 64'd0);
        check_eq("t6_rst_din", 64'(eng_din), 64'd0);
        check_eq("t6_rst_valid", 64'(rsp_valid), 64'd0);
        check_eq("t6_rst_id", 64'(rsp_id), 64'd0);
        step();
        check_eq("t6_rst_ready2", 64'(req_ready), 64'd0);
        req_valid = 4'b1111;
        rst_n     = 1'b1;
        wait_grant("t6_regrant", 0);
        wait_rsp("t6_regrant", 0, 1'b1, 8'h00, 1'b0, DATA_L + 1, 0);

        // Round robin with all lanes valid: 1, 2, 3, 0 follow
        wait_grant("rr1", 1);
        wait_rsp("rr1", 1, 1'b1, 8'h00, 1'b0, DATA_L + 1, 0);
        wait_grant("rr2", 2);
        wait_rsp("rr2", 2, 1'b0, 8'h01, 1'b0, DATA_L + 1, 0);
        wait_grant("rr3", 3);
        wait_rsp("rr3", 3, 1'b0, 8'h5A, 1'b0, DATA_L + 1, 0);
        wait_grant("rr4", 0);
        wait_rsp("rr4", 0, 1'b1, 8'h00, 1'b0, DATA_L + 1, 0);

        // Consumer stalls 10 cycles: response stable, no new grant
        wait_grant("t5", 1);
        wait_rsp("t5", 1, 1'b1, 8'h00, 1'b0, DATA_L + 1, 10);

        // Engine never answers: watchdog abort after TIMEOUT BUSY cycles
        eng_dead = 1'b1;
        wait_grant("t4", 2);
        wait_rsp("t4", 2, 1'b0, 8'h00, 1'b1, TIMEOUT, 0);
        eng_dead  = 1'b0;
        req_valid = 4'b0000;
        repeat (3) step();
        check_eq("end_idle", 64'(rsp_valid), 64'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
